// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (LSB first) with a three-state IDLE/RUN/DONE FSM.
// Optional build macro SERIAL_SUB_SAT_EN clamps diff to zero when the final borrow is set.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             busy,
   output logic             done
);

   localparam int unsigned   CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bo_q, bo_d;
   logic             done_q, done_d;
   logic             bit_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bo_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bo_q    <= bo_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bo_d    = bo_q;
      done_d  = 1'b0;
      bit_d   = a_q[0] ^ b_q[0] ^ br_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               res_d   = '0;
               br_d    = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // All WIDTH bits are in res_q once the counter reaches WIDTH; publish on this edge.
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               done_d  = 1'b1;
               bo_d    = br_q;
`ifdef SERIAL_SUB_SAT_EN
               diff_d  = br_q ? '0 : res_q;
`else
               diff_d  = res_q;
`endif
            end else begin
               br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
               a_d   = a_q >> 1;
               b_d   = b_q >> 1;
               res_d = {bit_d, res_q[WIDTH-1:1]};
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign diff       = diff_q;
   assign borrow_out = bo_q;
   assign done       = done_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): scoreboard queue of expected results,
// checked with immediate assertions when done is observed.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   typedef struct packed {
      logic [W-1:0] d;
      logic         br;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         busy;
   logic         done;

   int   checks;
   int   errors;
   exp_t sb_q[$];
   logic [W-1:0] held_diff;
   logic         held_br;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .diff       (diff),
      .borrow_out (borrow_out),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      e.br = (x < y);
      e.d  = x - y;
`ifdef SERIAL_SUB_SAT_EN
      if (e.br) e.d = '0;
`endif
      return e;
   endfunction

   // One full transaction; repulse re-asserts start with other operands at cycle 3 and in DONE.
   task automatic do_sub(input logic [W-1:0] x, input logic [W-1:0] y, input bit repulse);
      int   lat;
      exp_t e;
      sb_q.push_back(model(x, y));
      @(negedge clk);
      start = 1'b1;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = ~x;
      b     = y ^ 8'h5A;
      lat   = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
         check("busy_run", busy, 1);
         check("diff_hold", diff, held_diff);
         check("borrow_hold", borrow_out, held_br);
         if (repulse && n == 2) begin
            start = 1'b1;
            a     = 8'hAA;
            b     = 8'h01;
         end
      end
      check("latency", lat, 9);
      check("busy_done", busy, 1);
      e = sb_q.pop_front();
      if (lat != 0) begin
         check("diff", diff, e.d);
         check("borrow", borrow_out, e.br);
         held_diff = e.d;
         held_br   = e.br;
      end
      if (repulse) begin
         start = 1'b1;
         a     = 8'h77;
         b     = 8'h66;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      check("done_pulse", done, 0);
      check("busy_idle", busy, 0);
      check("diff_after", diff, held_diff);
      @(posedge clk);
      #1;
      check("idle_stays", busy, 0);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      held_diff = '0;
      held_br   = 1'b0;
      rst_n     = 1'b0;
      start     = 1'b0;
      a         = '0;
      b         = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_diff", diff, 0);
      check("rst_borrow", borrow_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_no_start", busy, 0);

      do_sub(8'h5A, 8'h23, 1'b0);
      do_sub(8'h00, 8'h01, 1'b0);
      do_sub(8'hFF, 8'hFF, 1'b0);
      do_sub(8'h10, 8'h20, 1'b0);
      do_sub(8'h33, 8'h11, 1'b1);

      // Abort mid-RUN: outputs clear immediately and no done appears.
      @(negedge clk);
      start = 1'b1;
      a     = 8'h12;
      b     = 8'h34;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("pre_abort_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("abort_diff", diff, 0);
      check("abort_borrow", borrow_out, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      held_diff = '0;
      held_br   = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk);
         #1;
         check("abort_no_done", done, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_sub(8'h80, 8'h01, 1'b0);

      for (int i = 0; i < 4; i++) begin
         do_sub(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b0);
      end
      check("sb_empty", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
